regfile_wb_arbiter: RTL

Write-port arbiter and scoreboard in front of the 32x32 general-purpose register file. The register file has one write port; this block shares it between the in-order pipeline writeback stage and a long-latency result source (divider or load return). The long-latency source goes through a one-entry holding buffer with a valid/ready handshake. A busy bitmap of outstanding long-latency destinations drives the decode-stage hazard stall.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register file and the logic
// that sits in front of its single write port.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // Which requester owns the write port in the current cycle
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_e;

  // One-hot decode of a register address into a bitmap position
  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    reg_mask_t mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bitmap of registers awaiting a long-latency result. Provides the
// issue acceptance check and the three decode-stage hazard checks.
// Register 0 is never busy, so it can never stall or hit a hazard.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t issue_addr,
  output logic      issue_ready,
  input  reg_addr_t chk_rs,
  input  reg_addr_t chk_rt,
  input  reg_addr_t chk_rd,
  input  logic [2:0] chk_en,
  output logic      hazard,
  output reg_mask_t busy
);

  reg_mask_t busy_next;

  // Next bitmap: drain clears first, then a new issue sets; bit 0 pinned low
  always_comb begin
    busy_next = busy;
    if (clr_en) begin
      busy_next = busy_next & ~reg_onehot(clr_addr);
    end
    if (set_en) begin
      busy_next = busy_next | reg_onehot(set_addr);
    end
    busy_next[0] = 1'b0;
  end

  // Bitmap register, wiped by reset together with the pipeline flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Issue and hazard checks look only at the registered bitmap, so a
  // same-cycle drain of the destination still rejects the issue
  always_comb begin
    issue_ready = (issue_addr == REG_ZERO) || !busy[issue_addr];
    hazard      = (chk_en[0] && busy[chk_rs]) ||
                  (chk_en[1] && busy[chk_rt]) ||
                  (chk_en[2] && busy[chk_rd]);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file. The pipeline writeback (A) is
// never back-pressured; long-latency results (B) wait in a one-entry buffer
// and take the port whenever A is idle or targets r0. A saturating counter
// tracks how long a held result has been losing and raises a front-end stall.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wbA_we_i,
  input  reg_addr_t  wbA_addr_i,
  input  reg_data_t  wbA_data_i,
  input  logic       reqB_valid_i,
  input  reg_addr_t  reqB_addr_i,
  input  reg_data_t  reqB_data_i,
  output logic       reqB_ready_o,
  input  logic       issue_valid_i,
  input  reg_addr_t  issue_addr_i,
  output logic       issue_ready_o,
  input  reg_addr_t  chk_rs_i,
  input  reg_addr_t  chk_rt_i,
  input  reg_addr_t  chk_rd_i,
  input  logic [2:0] chk_en_i,
  output logic       hazard_o,
  output logic       stall_o,
  output logic       writeEnable_o,
  output reg_addr_t  writeAddr_o,
  output reg_data_t  writeData_o,
  output reg_mask_t  busy_o
);

  localparam logic [2:0] STARVE_THRESH = 3'(STARVE_LIMIT);

  logic      hold_valid;
  reg_addr_t hold_addr;
  reg_data_t hold_data;
  logic [2:0] starve_cnt;
  grant_e    grant;
  logic      a_wins;
  logic      drain;
  logic      issue_set;

  // Grant: A with a real destination first, then the held result
  always_comb begin
    a_wins = wbA_we_i && (wbA_addr_i != REG_ZERO);
    grant  = GRANT_NONE;
    if (!rst) begin
      if (a_wins) begin
        grant = GRANT_A;
      end else if (hold_valid) begin
        grant = GRANT_B;
      end
    end
    drain = (grant == GRANT_B);
  end

  // Drive the register file port from the granted source
  always_comb begin
    writeEnable_o = 1'b0;
    writeAddr_o   = REG_ZERO;
    writeData_o   = '0;
    case (grant)
      GRANT_A: begin
        writeEnable_o = 1'b1;
        writeAddr_o   = wbA_addr_i;
        writeData_o   = wbA_data_i;
      end
      GRANT_B: begin
        writeEnable_o = (hold_addr != REG_ZERO);
        writeAddr_o   = hold_addr;
        writeData_o   = hold_data;
      end
      default: begin
        writeEnable_o = 1'b0;
      end
    endcase
  end

  assign reqB_ready_o = !hold_valid && !rst;

  // Holding buffer: capture on handshake, release on drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= REG_ZERO;
      hold_data  <= '0;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end else if (reqB_valid_i && reqB_ready_o) begin
      hold_valid <= 1'b1;
      hold_addr  <= reqB_addr_i;
      hold_data  <= reqB_data_i;
    end
  end

  // Starvation counter: counts edges a held result loses to A, saturates at 7
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (!hold_valid || drain) begin
      starve_cnt <= 3'd0;
    end else if ((grant == GRANT_A) && (starve_cnt != 3'd7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign stall_o   = (starve_cnt >= STARVE_THRESH);
  assign issue_set = issue_valid_i && issue_ready_o && (issue_addr_i != REG_ZERO);

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (issue_set),
    .set_addr    (issue_addr_i),
    .clr_en      (drain),
    .clr_addr    (hold_addr),
    .issue_addr  (issue_addr_i),
    .issue_ready (issue_ready_o),
    .chk_rs      (chk_rs_i),
    .chk_rt      (chk_rt_i),
    .chk_rd      (chk_rd_i),
    .chk_en      (chk_en_i),
    .hazard      (hazard_o),
    .busy        (busy_o)
  );

endmodule
